// File: rtl/sm_hex_pager_pkg.sv
// Shared definitions for the hex pager: debounce state encoding and counter sizing.
package sm_hex_pager_pkg;

    localparam int unsigned DB_STATE_W = 2;

    localparam logic [DB_STATE_W-1:0] ST_RELEASED     = 2'd0;
    localparam logic [DB_STATE_W-1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [DB_STATE_W-1:0] ST_PRESSED      = 2'd2;
    localparam logic [DB_STATE_W-1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_SEL_W = 2;

    // Bits needed to hold any count from 0 up to and including cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sm_debounce.sv
// Push-button conditioner: 2-FF synchronizer plus a stability-counting FSM that
// emits one keyPulse per accepted press, regardless of how long the key is held.
module sm_debounce
    import sm_hex_pager_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic keyPulse
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]            sync_q;
    logic [1:0]            sync_d;
    logic                  key_s;
    logic [DB_STATE_W-1:0] state_q;
    logic [DB_STATE_W-1:0] state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    // Shift the raw key into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[0], key_n};
    end

    // Synchronizer flops; idle level is released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign key_s = sync_q[1];

    // State register together with its stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a level change is accepted only after it stays stable long enough.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (!key_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (key_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output: pulse on the single cycle the press is accepted, so the consumer
    // acts on the same edge as the transition into PRESSED.
    always_comb begin
        keyPulse = 1'b0;
        if ((state_q == ST_PRESS_WAIT) && !key_s && (cnt_q == CNT_MAX)) begin
            keyPulse = 1'b1;
        end
    end

endmodule

// File: rtl/sm_hex_pager.sv
// Pages a 32-bit register word onto a two-digit hex display one byte at a time,
// stepping on a debounced key press or a periodic auto-rotate tick.
module sm_hex_pager
    import sm_hex_pager_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ROTATE_CYCLES   = 50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     data,
    input  logic                  key_n,
    input  logic                  autoRotate,
    input  logic                  freeze,
    output logic [BYTE_SEL_W-1:0] byteSel,
    output logic [NIBBLE_W-1:0]   digitHi,
    output logic [NIBBLE_W-1:0]   digitLo,
    output logic                  advance
);

    localparam int unsigned ROT_W = cnt_width(ROTATE_CYCLES);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);
    localparam logic [ROT_W-1:0] ROT_ONE  = ROT_W'(1);

    logic                  key_pulse_c;
    logic                  tick_c;
    logic                  step_c;
    logic [ROT_W-1:0]      rot_cnt_q;
    logic [ROT_W-1:0]      rot_cnt_d;
    logic [BYTE_SEL_W-1:0] byte_sel_q;
    logic [BYTE_SEL_W-1:0] byte_sel_d;
    logic                  advance_q;
    logic                  advance_d;
    logic [WORD_W-1:0]     snap_q;
    logic [WORD_W-1:0]     snap_d;
    logic [BYTE_W-1:0]     digits_q;
    logic [BYTE_W-1:0]     digits_d;

    sm_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .keyPulse (key_pulse_c)
    );

    // Rotate timer: free-runs while enabled, restarted by an accepted key press.
    always_comb begin
        rot_cnt_d = '0;
        tick_c    = 1'b0;
        if (autoRotate) begin
            if (rot_cnt_q == ROT_LAST) begin
                tick_c = 1'b1;
            end else begin
                rot_cnt_d = rot_cnt_q + ROT_ONE;
            end
        end
        if (key_pulse_c) begin
            rot_cnt_d = '0;
        end
    end

    // Byte index and advance pulse; a coincident key and tick count as one step.
    always_comb begin
        step_c     = key_pulse_c | tick_c;
        advance_d  = step_c;
        byte_sel_d = byte_sel_q;
        if (step_c) begin
            byte_sel_d = byte_sel_q + BYTE_SEL_W'(1);
        end
    end

    // Snapshot tracks data unless frozen; digits come from the current index.
    always_comb begin
        snap_d   = freeze ? snap_q : data;
        digits_d = snap_q[{byte_sel_q, 3'b000} +: BYTE_W];
    end

    // All pager state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_cnt_q  <= '0;
            byte_sel_q <= '0;
            advance_q  <= 1'b0;
            snap_q     <= '0;
            digits_q   <= '0;
        end else begin
            rot_cnt_q  <= rot_cnt_d;
            byte_sel_q <= byte_sel_d;
            advance_q  <= advance_d;
            snap_q     <= snap_d;
            digits_q   <= digits_d;
        end
    end

    assign byteSel = byte_sel_q;
    assign digitHi = digits_q[BYTE_W-1 -: NIBBLE_W];
    assign digitLo = digits_q[NIBBLE_W-1:0];
    assign advance = advance_q;

endmodule

// File: tb/tb_sm_hex_pager.sv
// Scoreboard bench for sm_hex_pager with a behavioural reference model.
module tb_sm_hex_pager;

    localparam int D = 4;
    localparam int R = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        key_n;
    logic        autoRotate;
    logic        freeze;
    logic [1:0]  byteSel;
    logic [3:0]  digitHi;
    logic [3:0]  digitLo;
    logic        advance;

    int checks   = 0;
    int failures = 0;
    int adv_seen = 0;

    sm_hex_pager #(
        .DEBOUNCE_CYCLES (D),
        .ROTATE_CYCLES   (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .key_n      (key_n),
        .autoRotate (autoRotate),
        .freeze     (freeze),
        .byteSel    (byteSel),
        .digitHi    (digitHi),
        .digitLo    (digitLo),
        .advance    (advance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounce as "a differing level must persist for D+1 samples before it is
    // adopted"; rotation as elapsed enabled cycles modulo R.
    bit   [1:0]  m_sync;
    bit          m_lvl;
    int          m_run;
    int          m_elapsed;
    int          m_sel;
    logic [31:0] m_snap;
    logic [7:0]  m_dig;
    bit          m_adv;
    logic [1:0]  exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        bit key_s;
        bit pulse;
        bit tick;
        if (!rst_n) begin
            m_sync    = 2'b11;
            m_lvl     = 1'b1;
            m_run     = 0;
            m_elapsed = 0;
            m_sel     = 0;
            m_snap    = 32'h0;
            m_dig     = 8'h0;
            m_adv     = 1'b0;
            exp_q.delete();
        end else begin
            key_s = m_sync[1];
            pulse = 1'b0;
            if (key_s != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = key_s;
                    m_run = 0;
                    pulse = !key_s;
                end
            end else begin
                m_run = 0;
            end
            tick = 1'b0;
            if (autoRotate) begin
                m_elapsed++;
                if (m_elapsed == R) begin
                    tick      = 1'b1;
                    m_elapsed = 0;
                end
            end else begin
                m_elapsed = 0;
            end
            if (pulse) m_elapsed = 0;
            m_dig = 8'((m_snap >> (8 * m_sel)) & 32'hFF);
            m_adv = pulse | tick;
            if (m_adv) begin
                m_sel = (m_sel + 1) % 4;
                exp_q.push_back(2'(m_sel));
            end
            if (!freeze) m_snap = data;
            m_sync = {m_sync[0], key_n};
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("byteSel", 32'(byteSel), 32'(m_sel));
            check("digits", 32'({digitHi, digitLo}), 32'(m_dig));
            check("advance", 32'(advance), 32'(m_adv));
            if (advance) begin
                adv_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL adv_unexpected actual=%0d expected=none at %0t", byteSel, $time);
                end else begin
                    check("adv_sel", 32'(byteSel), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        rst_n      = 1'b0;
        data       = 32'h12345678;
        key_n      = 1'b1;
        autoRotate = 1'b0;
        freeze     = 1'b0;
        step(3);
        check("rst_byteSel", 32'(byteSel), 0);
        check("rst_digits", 32'({digitHi, digitLo}), 0);
        check("rst_advance", 32'(advance), 0);
        rst_n = 1'b1;
        step(3);
        check("t1_digits", 32'({digitHi, digitLo}), 32'h78);
        check("t1_byteSel", 32'(byteSel), 0);

        // Short glitches never qualify.
        a0 = adv_seen;
        repeat (2) begin
            key_n = 1'b0; step(3);
            key_n = 1'b1; step(10);
        end
        check("t2_glitch_adv", 32'(adv_seen - a0), 0);
        key_n = 1'b0; step(30);
        check("t2_press_adv", 32'(adv_seen - a0), 1);
        check("t2_press_sel", 32'(byteSel), 1);
        check("t2_press_digits", 32'({digitHi, digitLo}), 32'h56);
        key_n = 1'b1; step(30);
        key_n = 1'b0; step(30);
        check("t2_repress_sel", 32'(byteSel), 2);
        check("t2_repress_digits", 32'({digitHi, digitLo}), 32'h34);
        key_n = 1'b1; step(30);

        // Auto-rotate: five ticks in 40 enabled cycles.
        a0 = adv_seen;
        autoRotate = 1'b1; step(40);
        autoRotate = 1'b0; step(2);
        check("t3_rot_adv", 32'(adv_seen - a0), 5);
        check("t3_rot_sel", 32'(byteSel), 3);
        key_n = 1'b0; step(30);
        key_n = 1'b1; step(30);
        check("t3_wrap_sel", 32'(byteSel), 0);
        check("t3_wrap_digits", 32'({digitHi, digitLo}), 32'h78);

        // Freeze holds the snapshot.
        freeze = 1'b1; step(1);
        data = 32'hDEADBEEF; step(6);
        check("t4_frozen", 32'({digitHi, digitLo}), 32'h78);
        freeze = 1'b0; step(3);
        check("t4_thawed", 32'({digitHi, digitLo}), 32'hEF);

        // Key acceptance lands on the same edge as the rotate wrap.
        autoRotate = 1'b1; step(1);
        key_n = 1'b0; step(6);
        check("t5_before", 32'(byteSel), 0);
        step(8);
        check("t5_single_step", 32'(byteSel), 1);
        step(1);
        check("t5_next_tick", 32'(byteSel), 2);
        autoRotate = 1'b0;
        key_n = 1'b1; step(30);

        // Reset in the middle of a press and a rotate period.
        autoRotate = 1'b1;
        key_n = 1'b0; step(5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_sel", 32'(byteSel), 0);
        check("t6_async_digits", 32'({digitHi, digitLo}), 0);
        check("t6_async_adv", 32'(advance), 0);
        autoRotate = 1'b0;
        step(2);
        rst_n = 1'b1;
        a0 = adv_seen;
        step(4);
        check("t6_no_early", 32'(adv_seen - a0), 0);
        step(10);
        check("t6_one_pulse", 32'(adv_seen - a0), 1);
        check("t6_sel", 32'(byteSel), 1);
        key_n = 1'b1; step(30);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int len;
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) key_n = ~key_n;
            if ($urandom_range(0, 5) == 0) autoRotate = ~autoRotate;
            if ($urandom_range(0, 6) == 0) freeze = ~freeze;
            if ($urandom_range(0, 1) == 0) data = $urandom;
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(len);
        end
        autoRotate = 1'b0;
        step(3);
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
